// File: rtl/ofmaps_axis_packer_if.sv
// AXI4-Stream link between the ofmap packer and the ofmap DMA.
// The master drives data/valid/last; the slave returns ready.
interface ofmaps_axis_packer_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ofmaps_axis_packer.sv
// Captures MAC result vectors into a two-entry ping-pong buffer and streams them
// out as sign-extended bytes over AXI4-Stream, with frame tlast/frame_done marking.
module ofmaps_axis_packer #(
    parameter int MAC_NUM         = 256,
    parameter int AXIS_DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [6*MAC_NUM-1:0]         MAC_out,
    input  logic                         MAC_o_valid,
    input  logic [15:0]                  frame_vectors,
    input  logic                         start,
    ofmaps_axis_packer_if.master         m_axis,
    output logic                         buf_full,
    output logic                         overflow,
    output logic                         frame_done
);
    localparam int LANES   = AXIS_DATA_WIDTH / 8;
    localparam int BEATS   = MAC_NUM / LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VEC_W   = 6 * MAC_NUM;
    localparam int SLICE_W = 6 * LANES;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t          state_reg, state_next;
    logic [VEC_W-1:0]    buf_reg [2];
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic [15:0]         vec_cnt_reg;
    logic [15:0]         frame_len_reg;
    logic                overflow_reg;
    logic                frame_done_reg;

    logic                tvalid;
    logic                last_beat;
    logic                tlast;
    logic                handshake;
    logic                pop;
    logic                push;
    logic                drop;
    logic                start_ok;
    logic [15:0]         frame_len_in;
    logic [15:0]         frame_len_eff;
    logic [VEC_W-1:0]    rd_vec;
    logic [SLICE_W-1:0]  rd_slice;

    // The frame length is taken live while the first vector of a frame is out,
    // then held for the rest of that frame.
    assign frame_len_in  = (frame_vectors == 16'd0) ? 16'd1 : frame_vectors;
    assign frame_len_eff = (vec_cnt_reg == 16'd0) ? frame_len_in : frame_len_reg;

    assign tvalid    = (state_reg != EMPTY);
    assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
    assign tlast     = tvalid && last_beat && (vec_cnt_reg == frame_len_eff - 16'd1);
    assign handshake = tvalid && m_axis.tready;
    assign pop       = handshake && last_beat;
    assign push      = MAC_o_valid && ((state_reg != FULL) || pop);
    assign drop      = MAC_o_valid && (state_reg == FULL) && !pop;
    assign start_ok  = start && (state_reg == EMPTY);

    always_comb begin
        state_next = state_reg;
        if (push && !pop) begin
            case (state_reg)
                EMPTY:   state_next = ONE;
                default: state_next = FULL;
            endcase
        end else if (pop && !push) begin
            case (state_reg)
                FULL:    state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= EMPTY;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_reg[0]     <= '0;
            buf_reg[1]     <= '0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            beat_reg       <= '0;
            vec_cnt_reg    <= '0;
            frame_len_reg  <= 16'd1;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (push) begin
                buf_reg[wr_ptr_reg] <= MAC_out;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (handshake) begin
                beat_reg <= last_beat ? '0 : beat_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                if (tlast) begin
                    vec_cnt_reg <= '0;
                end else begin
                    vec_cnt_reg <= vec_cnt_reg + 16'd1;
                    if (vec_cnt_reg == 16'd0) frame_len_reg <= frame_len_in;
                end
            end
            frame_done_reg <= pop && tlast;
            // start only lands on an empty buffer, so it never collides with a pop.
            if (start_ok) begin
                vec_cnt_reg  <= '0;
                overflow_reg <= 1'b0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign rd_vec   = buf_reg[rd_ptr_reg];
    assign rd_slice = rd_vec[beat_reg*SLICE_W +: SLICE_W];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign m_axis.tdata[8*gi +: 8] = {{2{rd_slice[6*gi+5]}}, rd_slice[6*gi +: 6]};
    end

    assign m_axis.tvalid = tvalid;
    assign m_axis.tlast  = tlast;
    assign buf_full      = (state_reg == FULL);
    assign overflow      = overflow_reg;
    assign frame_done    = frame_done_reg;
endmodule

// File: tb/tb_ofmaps_axis_packer.sv
// Scoreboard bench for ofmaps_axis_packer: stimulus queues expected beats,
// a negedge monitor pops and compares every handshake.
module tb_ofmaps_axis_packer;
    localparam int MAC_NUM = 256;
    localparam int W       = 64;
    localparam int L       = W / 8;
    localparam int BEATS   = MAC_NUM / L;
    localparam int VW      = 6 * MAC_NUM;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [VW-1:0] mac_out;
    logic          mac_o_valid;
    logic [15:0]   frame_vectors;
    logic          start;
    logic          buf_full;
    logic          overflow;
    logic          frame_done;
    logic          tready_cmd;
    logic          bp_en;
    logic [1:0]    bp_phase;

    ofmaps_axis_packer_if #(.DATA_WIDTH(W)) axis ();

    ofmaps_axis_packer #(.MAC_NUM(MAC_NUM), .AXIS_DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .MAC_out(mac_out), .MAC_o_valid(mac_o_valid),
        .frame_vectors(frame_vectors), .start(start), .m_axis(axis),
        .buf_full(buf_full), .overflow(overflow), .frame_done(frame_done)
    );

    assign axis.tready = bp_en ? ((bp_phase == 2'd0) || (bp_phase == 2'd3)) : tready_cmd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bp_en) bp_phase <= bp_phase + 2'd1;
        else       bp_phase <= 2'd0;
    end

    int           checks = 0;
    int           fails  = 0;
    int           rx_cnt = 0;
    int           fdc    = 0;
    beat_t        sb[$];
    logic [W-1:0] rx_log[$];
    int           last_pos[$];
    int           fv_model;
    int           vec_in_frame;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk_vec(input int seed);
        logic [VW-1:0] v;
        for (int i = 0; i < MAC_NUM; i++) v[6*i +: 6] = 6'((i + seed) % 64);
        return v;
    endfunction

    task automatic expect_vec(input int seed);
        logic [VW-1:0] v;
        logic [5:0]    p;
        beat_t         e;
        v = mk_vec(seed);
        for (int b = 0; b < BEATS; b++) begin
            e.d = '0;
            for (int k = 0; k < L; k++) begin
                p = v[6*(b*L+k) +: 6];
                e.d[8*k +: 8] = {p[5], p[5], p};
            end
            e.l = (b == BEATS - 1) && (vec_in_frame == fv_model - 1);
            sb.push_back(e);
        end
        vec_in_frame = (vec_in_frame == fv_model - 1) ? 0 : vec_in_frame + 1;
        $display("push vector seed=%0d queued=%0d", seed, sb.size());
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; drives a one-cycle capture strobe.
    task automatic pulse(input int seed);
        mac_out     = mk_vec(seed);
        mac_o_valid = 1'b1;
        expect_vec(seed);
        step(1);
        mac_o_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_rx(input int target, input int maxc);
        int n = 0;
        while (rx_cnt != target && n < maxc) begin
            step(1);
            n++;
        end
        chk("wait_rx", 64'(rx_cnt), 64'(target));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_tdata"}, axis.tdata, 64'd0);
        chk({tag, "_tvalid"}, 64'(axis.tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(axis.tlast), 64'd0);
        chk({tag, "_buf_full"}, 64'(buf_full), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    // Monitor: compares every handshake against the scoreboard head.
    initial begin
        beat_t        e;
        logic         fd_exp     = 1'b0;
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_data  = '0;
        logic         prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fd_exp     = 1'b0;
                prev_stall = 1'b0;
            end else begin
                chk("frame_done", 64'(frame_done), 64'(fd_exp));
                if (frame_done) fdc++;
                if (prev_stall) begin
                    chk("stall_tvalid", 64'(axis.tvalid), 64'd1);
                    chk("stall_tdata", axis.tdata, prev_data);
                    chk("stall_tlast", 64'(axis.tlast), 64'(prev_last));
                end
                fd_exp = 1'b0;
                if (axis.tvalid && axis.tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_beat actual=%h required=none", axis.tdata);
                    end else begin
                        e = sb.pop_front();
                        chk("tdata", axis.tdata, e.d);
                        chk("tlast", 64'(axis.tlast), 64'(e.l));
                    end
                    rx_log.push_back(axis.tdata);
                    if (axis.tlast) begin
                        last_pos.push_back(rx_cnt);
                        fd_exp = 1'b1;
                    end
                    rx_cnt++;
                end
                prev_stall = axis.tvalid && !axis.tready;
                prev_data  = axis.tdata;
                prev_last  = axis.tlast;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst           = 1'b1;
        mac_out       = '0;
        mac_o_valid   = 1'b0;
        frame_vectors = 16'd1;
        start         = 1'b0;
        tready_cmd    = 1'b1;
        bp_en         = 1'b0;
        fv_model      = 1;
        vec_in_frame  = 0;
        step(3);
        @(negedge clk);
        chk_idle_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        step(2);

        // 1: single-vector frame, psum i = i mod 64
        rx_log.delete(); last_pos.delete(); fdc = 0; base = rx_cnt;
        pulse(0);
        @(negedge clk);
        chk("latency_tvalid", 64'(axis.tvalid), 64'd1);
        chk("latency_beat0", axis.tdata, 64'h0706050403020100);
        @(posedge clk); #1;
        wait_drain(200);
        step(3);
        chk("s1_beats", 64'(rx_log.size()), 64'd32);
        if (rx_log.size() == 32) begin
            chk("s1_beat4", rx_log[4], 64'hE7E6E5E4E3E2E1E0);
            chk("s1_beat31", rx_log[31], 64'hFFFEFDFCFBFAF9F8);
        end
        chk("s1_tlast_count", 64'(last_pos.size()), 64'd1);
        if (last_pos.size() == 1) chk("s1_tlast_pos", 64'(last_pos[0] - base), 64'd31);
        chk("s1_frame_done", 64'(fdc), 64'd1);

        // 2: same vector under 1,0,0,1 backpressure
        rx_log.delete(); last_pos.delete(); fdc = 0;
        bp_en = 1'b1;
        pulse(0);
        wait_drain(400);
        step(3);
        bp_en = 1'b0;
        chk("s2_beats", 64'(rx_log.size()), 64'd32);
        if (rx_log.size() == 32) chk("s2_beat4", rx_log[4], 64'hE7E6E5E4E3E2E1E0);
        chk("s2_frame_done", 64'(fdc), 64'd1);

        // 3: overflow with tready low, strobes at cycles 0, 2, 4
        tready_cmd = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (c == 0 || c == 2 || c == 4) begin
                mac_out     = mk_vec(10 + c);
                mac_o_valid = 1'b1;
                if (c < 4) expect_vec(10 + c);
            end else begin
                mac_o_valid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("s3_buf_full_c%0d", c), 64'(buf_full), 64'(c >= 3));
            chk($sformatf("s3_overflow_c%0d", c), 64'(overflow), 64'(c >= 5));
            @(posedge clk); #1;
        end
        mac_o_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("s3_start_ignored", 64'(overflow), 64'd1);
        @(posedge clk); #1;
        base = rx_cnt;
        tready_cmd = 1'b1;
        wait_drain(300);
        step(5);
        chk("s3_beats", 64'(rx_cnt - base), 64'd64);
        chk("s3_overflow_held", 64'(overflow), 64'd1);
        pulse_start();
        @(negedge clk);
        chk("s3_start_clears", 64'(overflow), 64'd0);
        @(posedge clk); #1;

        // 4: push coincides with the final-beat pop while full
        tready_cmd = 1'b0;
        pulse(40);
        pulse(41);
        @(negedge clk);
        chk("s4_full", 64'(buf_full), 64'd1);
        @(posedge clk); #1;
        base = rx_cnt;
        tready_cmd = 1'b1;
        wait_rx(base + 31, 100);
        pulse(42);
        @(negedge clk);
        chk("s4_still_full", 64'(buf_full), 64'd1);
        chk("s4_no_overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        wait_drain(300);
        step(3);
        chk("s4_beats", 64'(rx_cnt - base), 64'd96);
        chk("s4_overflow_end", 64'(overflow), 64'd0);

        // 5: three-vector frames, six vectors
        frame_vectors = 16'd3; fv_model = 3; vec_in_frame = 0;
        pulse_start();
        base = rx_cnt; last_pos.delete(); fdc = 0;
        for (int j = 0; j < 6; j++) begin
            pulse(20 + j);
            step(BEATS - 1);
        end
        wait_drain(300);
        step(3);
        chk("s5_tlast_count", 64'(last_pos.size()), 64'd2);
        if (last_pos.size() == 2) begin
            chk("s5_tlast_pos0", 64'(last_pos[0] - base), 64'd95);
            chk("s5_tlast_pos1", 64'(last_pos[1] - base), 64'd191);
        end
        chk("s5_frame_done", 64'(fdc), 64'd2);

        // 6: reset during beat 10 of the second vector of a two-vector frame
        frame_vectors = 16'd2; fv_model = 2; vec_in_frame = 0;
        pulse_start();
        pulse(30);
        wait_drain(100);
        base = rx_cnt;
        pulse(31);
        wait_rx(base + 10, 100);
        rst = 1'b1;
        sb.delete();
        vec_in_frame = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("midrst");
        @(posedge clk); #1;
        base = rx_cnt; last_pos.delete();
        pulse(32);
        step(BEATS - 1);
        pulse(33);
        wait_drain(200);
        step(3);
        chk("s6_beats", 64'(rx_cnt - base), 64'd64);
        chk("s6_tlast_count", 64'(last_pos.size()), 64'd1);
        if (last_pos.size() == 1) chk("s6_tlast_pos", 64'(last_pos[0] - base), 64'd63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
